// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-file slave with independent write (AW/W/B) and read (AR/R) channels.
// Optional macro AXI_LITE_REG_SLAVE_SLVERR_EN: out-of-range indices return SLVERR instead of wrapping.
module axi_lite_reg_slave #(
  parameter int unsigned ADDR_WD = 8,
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned REG_NUM = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       awvalid,
  input  logic [ADDR_WD-1:0]         awaddr,
  output logic                       awready,
  input  logic                       wvalid,
  input  logic [DATA_WD-1:0]         wdata,
  output logic                       wready,
  output logic                       bvalid,
  output logic [1:0]                 bresp,
  input  logic                       bready,
  input  logic                       arvalid,
  input  logic [ADDR_WD-1:0]         araddr,
  output logic                       arready,
  output logic                       rvalid,
  output logic [DATA_WD-1:0]         rdata,
  output logic [1:0]                 rresp,
  input  logic                       rready,
  output logic [REG_NUM*DATA_WD-1:0] reg_q
);

  localparam int unsigned IDX_WD      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                 aw_full;
  logic                 w_full;
  logic [IDX_WD-1:0]    aw_idx_q;
  logic                 aw_err_q;
  logic [DATA_WD-1:0]   w_data_q;
  logic [DATA_WD-1:0]   regs [REG_NUM];

  logic                 aw_fire_c;
  logic                 w_fire_c;
  logic                 ar_fire_c;
  logic                 commit_c;
  logic                 aw_err_c;
  logic                 ar_err_c;
  logic [IDX_WD-1:0]    aw_idx_c;
  logic [IDX_WD-1:0]    ar_idx_c;

  // Index decode: range check when SLVERR is enabled, otherwise wrap on the low bits
`ifdef AXI_LITE_REG_SLAVE_SLVERR_EN
  localparam logic [ADDR_WD:0] REG_LIMIT = (ADDR_WD+1)'(REG_NUM);
  assign aw_err_c = ({1'b0, awaddr} >= REG_LIMIT);
  assign ar_err_c = ({1'b0, araddr} >= REG_LIMIT);
`else
  logic unused_addr;
  assign aw_err_c    = 1'b0;
  assign ar_err_c    = 1'b0;
  assign unused_addr = ^{awaddr, araddr};
`endif
  assign aw_idx_c = awaddr[IDX_WD-1:0];
  assign ar_idx_c = araddr[IDX_WD-1:0];

  // Ready signals come purely from state flops
  assign awready = !aw_full && !bvalid;
  assign wready  = !w_full && !bvalid;
  assign arready = !rvalid;

  assign aw_fire_c = awvalid && awready;
  assign w_fire_c  = wvalid && wready;
  assign ar_fire_c = arvalid && arready;
  assign commit_c  = aw_full && w_full;

  // Write channel: hold AW and W independently, commit once both are present
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx_q <= '0;
      aw_err_q <= 1'b0;
      w_data_q <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      if (aw_fire_c) begin
        aw_full  <= 1'b1;
        aw_idx_q <= aw_idx_c;
        aw_err_q <= aw_err_c;
      end
      if (w_fire_c) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
      end
      if (commit_c) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_err_q ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Register file; erroneous writes are acknowledged but dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (commit_c && !aw_err_q) begin
      regs[aw_idx_q] <= w_data_q;
    end
  end

  // Read channel: one outstanding read, data captured before any same-edge write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_fire_c) begin
      rvalid <= 1'b1;
      rdata  <= ar_err_c ? '0 : regs[ar_idx_c];
      rresp  <= ar_err_c ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  for (genvar i = 0; i < int'(REG_NUM); i++) begin : g_reg_q
    assign reg_q[i*DATA_WD +: DATA_WD] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed scenarios plus randomized
// write/read traffic checked against an array model of the register file.
module tb_axi_lite_reg_slave;

  localparam int unsigned ADDR_WD = 8;
  localparam int unsigned DATA_WD = 8;
  localparam int unsigned REG_NUM = 16;

  logic                       clk;
  logic                       rst_n;
  logic                       awvalid;
  logic [ADDR_WD-1:0]         awaddr;
  logic                       awready;
  logic                       wvalid;
  logic [DATA_WD-1:0]         wdata;
  logic                       wready;
  logic                       bvalid;
  logic [1:0]                 bresp;
  logic                       bready;
  logic                       arvalid;
  logic [ADDR_WD-1:0]         araddr;
  logic                       arready;
  logic                       rvalid;
  logic [DATA_WD-1:0]         rdata;
  logic [1:0]                 rresp;
  logic                       rready;
  logic [REG_NUM*DATA_WD-1:0] reg_q;

  int checks = 0;
  int errors = 0;
  logic [7:0] mregs [16];

  axi_lite_reg_slave #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .REG_NUM(REG_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .reg_q(reg_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_err(input int idx);
`ifdef AXI_LITE_REG_SLAVE_SLVERR_EN
    return idx >= 16;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int map_idx(input int idx);
    return idx % 16;
  endfunction

  function automatic logic [7:0] exp_rd(input int idx);
    return is_err(idx) ? 8'h00 : mregs[map_idx(idx)];
  endfunction

  function automatic logic [1:0] exp_resp(input int idx);
    return is_err(idx) ? 2'b10 : 2'b00;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_reg%0d", tag, i), 32'(reg_q[i*8 +: 8]), 32'(mregs[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
  endtask

  // One write transaction; AW and W offered after independent delays, B held b_dly cycles
  task automatic do_write(input int idx, input logic [7:0] data,
                          input int aw_dly, input int w_dly, input int b_dly);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = (cyc >= aw_dly) && !aw_done;
      awaddr  = ADDR_WD'(idx);
      wvalid  = (cyc >= w_dly) && !w_done;
      wdata   = data;
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      tick();
      aw_done |= aw_f;
      w_done  |= w_f;
      cyc++;
      if (!(aw_done && w_done)) begin
        check("wr_bvalid_early", 32'(bvalid), 0);
        if (w_done) check("wr_wready_held", 32'(wready), 0);
        if (aw_done) check("wr_awready_held", 32'(awready), 0);
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", 0, 1);
      return;
    end
    check("wr_commit_cycle_bvalid", 32'(bvalid), 0);
    check("wr_commit_cycle_awready", 32'(awready), 0);
    tick();
    if (!is_err(idx)) mregs[map_idx(idx)] = data;
    check("wr_bvalid", 32'(bvalid), 1);
    check("wr_bresp", 32'(bresp), 32'(exp_resp(idx)));
    check_regs("wr");
    for (int k = 0; k < b_dly; k++) begin
      tick();
      check("wr_bvalid_stall", 32'(bvalid), 1);
      check("wr_bresp_stall", 32'(bresp), 32'(exp_resp(idx)));
      check("wr_ready_stall", 32'({awready, wready}), 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("wr_bvalid_clear", 32'(bvalid), 0);
    check("wr_ready_back", 32'({awready, wready}), 3);
  endtask

  // One read transaction; R held r_dly cycles before rready
  task automatic do_read(input int idx, input int r_dly);
    logic [7:0] ed;
    logic [1:0] er;
    ed = exp_rd(idx);
    er = exp_resp(idx);
    check("rd_arready_idle", 32'(arready), 1);
    arvalid = 1'b1;
    araddr  = ADDR_WD'(idx);
    tick();
    arvalid = 1'b0;
    check("rd_rvalid", 32'(rvalid), 1);
    check("rd_rdata", 32'(rdata), 32'(ed));
    check("rd_rresp", 32'(rresp), 32'(er));
    for (int k = 0; k < r_dly; k++) begin
      tick();
      check("rd_stall", 32'({rvalid, rdata, rresp}), 32'({1'b1, ed, er}));
      check("rd_arready_stall", 32'(arready), 0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rd_rvalid_clear", 32'(rvalid), 0);
    check("rd_arready_back", 32'(arready), 1);
  endtask

  initial begin
    int idx;
    logic [7:0] d;
    rst_n = 1'b0; awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0;
    bready = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_outs", 32'({bvalid, bresp, rvalid, rdata, rresp}), 0);
    check("rst_readies", 32'({awready, wready, arready}), 7);
    check_regs("rst");

    // AW and W together, then read back
    do_write(3, 8'hA5, 0, 0, 0);
    do_read(3, 0);

    // W three cycles before AW
    do_write(7, 8'h5A, 3, 0, 0);
    do_read(7, 1);

    // B stalled five cycles, next write right after
    do_write(9, 8'h42, 0, 1, 5);
    do_write(10, 8'hC3, 0, 0, 0);

    // Out-of-range index
    do_write(8'h12, 8'h3C, 0, 0, 0);
    do_read(8'h12, 0);

    // Read captured on the commit edge returns the old value
    do_write(4, 8'h11, 0, 0, 0);
    awvalid = 1'b1; awaddr = 8'd4; wvalid = 1'b1; wdata = 8'h99;
    check("coll_ready", 32'({awready, wready}), 3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 8'd4;
    check("coll_arready", 32'(arready), 1);
    tick();
    arvalid = 1'b0;
    check("coll_rdata_old", 32'(rdata), 32'h11);
    check("coll_valids", 32'({bvalid, rvalid}), 3);
    mregs[4] = 8'h99;
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    check("coll_clear", 32'({bvalid, rvalid}), 0);
    do_read(4, 0);

    // Reset while an AW is held, before its W
    awvalid = 1'b1; awaddr = 8'd1;
    tick();
    awvalid = 1'b0;
    check("mid_aw_held", 32'(awready), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    check("mid_rst_bvalid", 32'(bvalid), 0);
    check("mid_rst_readies", 32'({awready, wready, arready}), 7);
    check_regs("mid_rst");
    tick();
    tick();
    check("mid_rst_no_commit", 32'(bvalid), 0);
    check_regs("mid_rst_idle");
    do_write(1, 8'h77, 0, 0, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 255)) : int'($urandom_range(0, 15));
      d   = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(idx, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_read(idx, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WD, default 8, address width in bits (register index, not byte address).
REQ-002 SHALL have parameter DATA_WD, default 8, register and data width in bits.
REQ-003 SHALL have parameter REG_NUM, default 16, number of registers; it SHALL be a power of two and ≤ 2^ADDR_WD.
REQ-004 SHALL have one clock, clk, and a synchronous active-low reset, rst_n, sampled on the rising edge of clk.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- awvalid  in  1  write address valid
- awaddr  in  ADDR_WD  write register index
- awready  out  1  write address accept
- wvalid  in  1  write data valid
- wdata  in  DATA_WD  write data
- wready  out  1  write data accept
- bvalid  out  1  write response valid
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- bready  in  1  write response accept
- arvalid  in  1  read address valid
- araddr  in  ADDR_WD  read register index
- arready  out  1  read address accept
- rvalid  out  1  read data valid
- rdata  out  DATA_WD  read data
- rresp  out  2  read response, encoded as for bresp
- rready  in  1  read data accept
- reg_q  out  REG_NUM*DATA_WD  flat register contents; register i occupies bits [i*DATA_WD +: DATA_WD]

Function
REQ-006 SHALL derive awready, wready and arready only from internal registers, with no combinational path from any input.
REQ-007 SHALL hold internal flags aw_full and w_full; awready = !aw_full && !bvalid, and wready = !w_full && !bvalid.
REQ-008 On an AW handshake, the block SHALL latch awaddr and set aw_full; on a W handshake, it SHALL latch wdata and set w_full; AW and W may arrive in either order or in the same cycle.
REQ-009 On any edge where aw_full && w_full, the block SHALL commit the write to the register file, set bvalid, load bresp, and clear both flags.
REQ-010 Write latency: with AW and W firing in cycle T, the register updates and bvalid rises at the T+1 edge, so both are visible in cycle T+2.
REQ-011 bvalid and bresp SHALL hold stable until bready is high; bvalid clears on that edge, and a new AW/W may fire in the following cycle.
REQ-012 arready = !rvalid.
REQ-013 On an AR handshake in cycle T, the block SHALL register rdata and rresp and raise rvalid, all visible in cycle T+1.
REQ-014 rvalid, rdata and rresp SHALL hold stable until rready is high; rvalid clears on that edge, giving a maximum read throughput of one read per 2 cycles.
REQ-015 The read and write channels SHALL be independent; simultaneous read and write activity SHALL be allowed.
REQ-016 If a read captures on the same edge as a write commit to the same index, the read SHALL return the pre-write value.
REQ-017 reg_q SHALL reflect register contents registered, updating on the commit edge.
REQ-018 When awvalid/wvalid/arvalid are held with ready low, the block SHALL neither drop nor duplicate the transfer.

Reset
REQ-019 While rst_n is low at a clk edge, the block SHALL clear all registers, aw_full, w_full, bvalid, rvalid, bresp, rresp and rdata to 0.
REQ-020 After reset, awready, wready and arready SHALL be 1.
REQ-021 If reset is asserted mid-transaction, the block SHALL discard any held AW/W and any pending B/R response without committing the write.

Configuration
REQ-022 Macro AXI_LITE_REG_SLAVE_SLVERR_EN: when defined, an index ≥ REG_NUM SHALL return SLVERR; such a write SHALL be dropped, and such a read SHALL return rdata = 0.
REQ-023 When AXI_LITE_REG_SLAVE_SLVERR_EN is undefined, the index SHALL wrap modulo REG_NUM (low log2(REG_NUM) bits) and always return OKAY.

Verification
REQ-024 Reset, then AW=0x03 and W=0xA5 in the same cycle -> bvalid in T+2, bresp=00, reg 3=0xA5; AR=0x03 -> rdata=0xA5, rresp=00 one cycle after the AR handshake.
REQ-025 W=0x5A three cycles before AW=0x07 -> wready low after the W handshake, commit occurs one cycle after AW, reg 7=0x5A, exactly one bvalid.
REQ-026 bready held low for 5 cycles after bvalid -> bvalid/bresp stable, awready=wready=0 throughout; a second write is accepted the cycle after bready=1.
REQ-027 Write 0x3C to index 0x12 (REG_NUM=16) -> with the macro: bresp=10, registers unchanged, read of 0x12 gives rresp=10, rdata=0; without the macro: reg 2=0x3C, OKAY.
REQ-028 Read of index 4 captured on the same edge as a write commit of 0x99 to index 4 (old value 0x11) -> rdata=0x11; the next read returns 0x99.
REQ-029 rst_n low one cycle after AW=0x01 fires, before W -> no register change, bvalid stays 0, and awready=wready=arready=1 after reset.
